classifier_argmax: RTL and testbench

//  Streaming, parametrised argmax/top-2 stage for the CNN classifier output. Accepts one class score
//  per cycle from fc_layer over a valid/ready stream; reports winning class index, max score,

---
 rtl/classifier_argmax_pkg.sv | 18 +
 rtl/classifier_argmax_if.sv | 34 +++
 rtl/classifier_argmax_score_cmp.sv | 19 +
 rtl/classifier_argmax.sv | 171 +++++++++++++++++
 tb/tb_classifier_argmax.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/classifier_argmax_pkg.sv
// Shared types and defaults for the streaming argmax / top-2 classifier stage.
package classifier_argmax_pkg;

    localparam int unsigned NUM_CLASSES_DEF = 10;
    localparam int unsigned PROB_W          = 113;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } argmax_state_t;

    // Index width for a class count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/classifier_argmax_if.sv
// Score stream in, held result out. Master = producer/consumer side, slave = argmax block.
interface classifier_argmax_if
    import classifier_argmax_pkg::*;
#(
    parameter int unsigned SCORE_W = PROB_W,
    parameter int unsigned IDX_W   = 4
) ();

    logic               start;
    logic               score_valid;
    logic               score_ready;
    logic [SCORE_W-1:0] score_data;
    logic               score_last;
    logic               result_valid;
    logic               result_ready;
    logic [IDX_W-1:0]   result_idx;
    logic [SCORE_W-1:0] result_max;
    logic [IDX_W-1:0]   result_second_idx;
    logic [SCORE_W:0]   result_margin;
    logic               err_len;

    modport master (
        output start, score_valid, score_data, score_last, result_ready,
        input  score_ready, result_valid, result_idx, result_max,
               result_second_idx, result_margin, err_len
    );

    modport slave (
        input  start, score_valid, score_data, score_last, result_ready,
        output score_ready, result_valid, result_idx, result_max,
               result_second_idx, result_margin, err_len
    );

endinterface

// File: rtl/classifier_argmax_score_cmp.sv
// Strict greater-than compare of two scores, signed or unsigned.
module classifier_argmax_score_cmp
    import classifier_argmax_pkg::*;
#(
    parameter int unsigned SCORE_W     = PROB_W,
    parameter bit          SIGNED_MODE = 1'b1
) (
    input  logic [SCORE_W-1:0] a_i,
    input  logic [SCORE_W-1:0] b_i,
    output logic               gt_o
);

    // a > b under the selected number interpretation
    always_comb begin
        if (SIGNED_MODE) gt_o = $signed(a_i) > $signed(b_i);
        else             gt_o = a_i > b_i;
    end

endmodule

// File: rtl/classifier_argmax.sv
// Streaming argmax / runner-up tracker: one score per beat, result held until accepted.
module classifier_argmax
    import classifier_argmax_pkg::*;
#(
    parameter int unsigned  NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned  SCORE_W     = PROB_W,
    parameter bit           SIGNED_MODE = 1'b1,
    localparam int unsigned IDX_W       = idx_width(NUM_CLASSES)
) (
    input  logic                clk,
    input  logic                rst,
    classifier_argmax_if.slave  arg_if
);

    localparam int unsigned       CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  NUM_C = CNT_W'(NUM_CLASSES);

    argmax_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_b;
    logic [SCORE_W-1:0] max_q, max_d, sec_q, sec_d;
    logic [IDX_W-1:0]   idx_q, idx_d, sec_idx_q, sec_idx_d;
    logic               sec_vld_q, sec_vld_d, err_q, err_d;
    logic               res_valid_q, res_valid_d, res_err_q, res_err_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d, res_sec_idx_q, res_sec_idx_d;
    logic [SCORE_W-1:0] res_max_q, res_max_d;
    logic [SCORE_W:0]   res_margin_q, res_margin_d;
    logic               beat, max_gt, sec_gt;

    function automatic logic [SCORE_W:0] ext(input logic [SCORE_W-1:0] v);
        return SIGNED_MODE ? {v[SCORE_W-1], v} : {1'b0, v};
    endfunction

    classifier_argmax_score_cmp #(.SCORE_W(SCORE_W), .SIGNED_MODE(SIGNED_MODE)) u_cmp_max (
        .a_i(arg_if.score_data), .b_i(max_q), .gt_o(max_gt)
    );

    classifier_argmax_score_cmp #(.SCORE_W(SCORE_W), .SIGNED_MODE(SIGNED_MODE)) u_cmp_sec (
        .a_i(arg_if.score_data), .b_i(sec_q), .gt_o(sec_gt)
    );

    assign beat = arg_if.score_valid && (state_q == ACCUM);

    // Next-state: frame control, top-2 tracking and result capture on the last beat
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        max_d         = max_q;
        idx_d         = idx_q;
        sec_d         = sec_q;
        sec_idx_d     = sec_idx_q;
        sec_vld_d     = sec_vld_q;
        err_d         = err_q;
        res_valid_d   = res_valid_q;
        res_idx_d     = res_idx_q;
        res_max_d     = res_max_q;
        res_sec_idx_d = res_sec_idx_q;
        res_margin_d  = res_margin_q;
        res_err_d     = res_err_q;
        cnt_b         = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arg_if.start) begin
                    state_d   = ACCUM;
                    cnt_d     = '0;
                    max_d     = '0;
                    idx_d     = '0;
                    sec_d     = '0;
                    sec_idx_d = '0;
                    sec_vld_d = 1'b0;
                    err_d     = 1'b0;
                end
            end
            ACCUM: begin
                // A restart clears the trackers; a beat arriving with it opens the new frame.
                if (arg_if.start) begin
                    cnt_b     = '0;
                    cnt_d     = '0;
                    max_d     = '0;
                    idx_d     = '0;
                    sec_d     = '0;
                    sec_idx_d = '0;
                    sec_vld_d = 1'b0;
                    err_d     = 1'b0;
                end
                if (beat) begin
                    if (cnt_b >= NUM_C) begin
                        err_d = 1'b1;
                    end else begin
                        if (cnt_b == '0) begin
                            max_d     = arg_if.score_data;
                            idx_d     = '0;
                            sec_vld_d = 1'b0;
                        end else if (max_gt) begin
                            sec_d     = max_q;
                            sec_idx_d = idx_q;
                            sec_vld_d = 1'b1;
                            max_d     = arg_if.score_data;
                            idx_d     = cnt_b[IDX_W-1:0];
                        end else if (!sec_vld_q || sec_gt) begin
                            sec_d     = arg_if.score_data;
                            sec_idx_d = cnt_b[IDX_W-1:0];
                            sec_vld_d = 1'b1;
                        end
                        cnt_d = cnt_b + CNT_W'(1);
                    end
                    if (arg_if.score_last) begin
                        if ((cnt_b + CNT_W'(1)) < NUM_C) err_d = 1'b1;
                        state_d       = HOLD;
                        res_valid_d   = 1'b1;
                        res_idx_d     = idx_d;
                        res_max_d     = max_d;
                        res_sec_idx_d = sec_vld_d ? sec_idx_d : '0;
                        res_margin_d  = sec_vld_d ? (ext(max_d) - ext(sec_d)) : '0;
                        res_err_d     = err_d;
                    end
                end
            end
            HOLD: begin
                if (arg_if.result_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            max_q         <= '0;
            idx_q         <= '0;
            sec_q         <= '0;
            sec_idx_q     <= '0;
            sec_vld_q     <= 1'b0;
            err_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
            res_max_q     <= '0;
            res_sec_idx_q <= '0;
            res_margin_q  <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            max_q         <= max_d;
            idx_q         <= idx_d;
            sec_q         <= sec_d;
            sec_idx_q     <= sec_idx_d;
            sec_vld_q     <= sec_vld_d;
            err_q         <= err_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
            res_max_q     <= res_max_d;
            res_sec_idx_q <= res_sec_idx_d;
            res_margin_q  <= res_margin_d;
            res_err_q     <= res_err_d;
        end
    end

    assign arg_if.score_ready       = (state_q == ACCUM);
    assign arg_if.result_valid      = res_valid_q;
    assign arg_if.result_idx        = res_idx_q;
    assign arg_if.result_max        = res_max_q;
    assign arg_if.result_second_idx = res_sec_idx_q;
    assign arg_if.result_margin     = res_margin_q;
    assign arg_if.err_len           = res_err_q;

endmodule

// File: tb/tb_classifier_argmax.sv
// Drives a signed and an unsigned instance with the same frames and checks both
// against a sort-style top-2 reference computed from the whole frame.
module tb_classifier_argmax;
    import classifier_argmax_pkg::*;

    localparam int unsigned NC = 10;
    localparam int unsigned SW = 113;
    localparam int unsigned IW = 4;

    typedef logic [SW-1:0] score_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   start = 1'b0, valid = 1'b0, last = 1'b0, rready = 1'b0;
    score_t data = '0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    classifier_argmax_if #(.SCORE_W(SW), .IDX_W(IW)) if_s ();
    classifier_argmax_if #(.SCORE_W(SW), .IDX_W(IW)) if_u ();

    assign if_s.start = start;        assign if_u.start = start;
    assign if_s.score_valid = valid;  assign if_u.score_valid = valid;
    assign if_s.score_data = data;    assign if_u.score_data = data;
    assign if_s.score_last = last;    assign if_u.score_last = last;
    assign if_s.result_ready = rready; assign if_u.result_ready = rready;

    classifier_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .SIGNED_MODE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .arg_if(if_s)
    );
    classifier_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .SIGNED_MODE(1'b0)) dut_u (
        .clk(clk), .rst(rst), .arg_if(if_u)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic score_t sc(input int v);
        return SW'(v);
    endfunction

    function automatic bit gt(input score_t a, input score_t b, input bit sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    // Winner = highest score, lowest index on ties; runner-up = same rule over the rest.
    task automatic ref_model(input score_t q[$], input bit sgn,
                             output logic [IW-1:0] e_idx, output score_t e_max,
                             output logic [IW-1:0] e_sidx, output logic [SW:0] e_mar,
                             output logic e_err);
        int m;
        int best;
        int sec;
        logic [SW:0] a, b;
        m = (q.size() < NC) ? q.size() : NC;
        best = 0;
        sec = -1;
        for (int i = 1; i < m; i++) if (gt(q[i], q[best], sgn)) best = i;
        for (int i = 0; i < m; i++) begin
            if (i != best && (sec < 0 || gt(q[i], q[sec], sgn))) sec = i;
        end
        e_idx = IW'(best);
        e_max = q[best];
        e_err = (q.size() != NC);
        if (sec < 0) begin
            e_sidx = '0;
            e_mar  = '0;
        end else begin
            a = sgn ? {q[best][SW-1], q[best]} : {1'b0, q[best]};
            b = sgn ? {q[sec][SW-1], q[sec]} : {1'b0, q[sec]};
            e_sidx = IW'(sec);
            e_mar  = a - b;
        end
    endtask

    task automatic check_outputs(input score_t q[$], input string tag);
        logic [IW-1:0] ei, esi;
        score_t        em;
        logic [SW:0]   emar;
        logic          ee;
        ref_model(q, 1'b1, ei, em, esi, emar, ee);
        chk({tag, "_s_idx"},  128'(if_s.result_idx),        128'(ei));
        chk({tag, "_s_max"},  128'(if_s.result_max),        128'(em));
        chk({tag, "_s_sidx"}, 128'(if_s.result_second_idx), 128'(esi));
        chk({tag, "_s_mar"},  128'(if_s.result_margin),     128'(emar));
        chk({tag, "_s_err"},  128'(if_s.err_len),           128'(ee));
        ref_model(q, 1'b0, ei, em, esi, emar, ee);
        chk({tag, "_u_idx"},  128'(if_u.result_idx),        128'(ei));
        chk({tag, "_u_max"},  128'(if_u.result_max),        128'(em));
        chk({tag, "_u_sidx"}, 128'(if_u.result_second_idx), 128'(esi));
        chk({tag, "_u_mar"},  128'(if_u.result_margin),     128'(emar));
        chk({tag, "_u_err"},  128'(if_u.err_len),           128'(ee));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input score_t d, input bit l);
        int unsigned w = 0;
        valid = 1'b1;
        data  = d;
        last  = l;
        while (!if_s.score_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("beat_ready_s", 128'(if_s.score_ready), 128'(1'b1));
        chk("beat_ready_u", 128'(if_u.score_ready), 128'(1'b1));
        if (if_s.score_ready) @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic send_frame(input score_t q[$]);
        pulse_start();
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(q[i], i == q.size() - 1);
        end
    endtask

    // Checks the result one cycle after the last beat, across a stall, and after the handshake.
    task automatic check_frame(input score_t q[$], input string tag, input int stall);
        chk({tag, "_s_lat"}, 128'(if_s.result_valid), 128'(1'b1));
        chk({tag, "_u_lat"}, 128'(if_u.result_valid), 128'(1'b1));
        check_outputs(q, tag);
        for (int k = 0; k < stall; k++) begin
            start = (k == 1);
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_stall_v"}, 128'(if_s.result_valid), 128'(1'b1));
            chk({tag, "_stall_r"}, 128'(if_s.score_ready),  128'(1'b0));
            check_outputs(q, {tag, "_stall"});
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({tag, "_s_drop"}, 128'(if_s.result_valid), 128'(1'b0));
        chk({tag, "_u_drop"}, 128'(if_u.result_valid), 128'(1'b0));
        chk({tag, "_idle_r"}, 128'(if_s.score_ready),  128'(1'b0));
        check_outputs(q, {tag, "_kept"});
    endtask

    function automatic score_t rnd_score();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 2))
            0: return t[SW-1:0];
            1: return sc(int'($urandom_range(0, 6)) - 3);
            default: return {t[0], {(SW-1){1'b0}}} | score_t'(t[2:1]);
        endcase
    endfunction

    task automatic rnd_frame(input int n, output score_t q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(rnd_score());
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        score_t q[$];
        score_t big;
        int     spec_v[10];
        int     n;

        spec_v = '{3, 9, -2, 7, 0, 1, 5, 8, 4, 6};
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(if_s.result_valid), 128'(1'b0));
        chk("rst_ready", 128'(if_s.score_ready),  128'(1'b0));
        chk("rst_idx",   128'(if_s.result_idx),   128'(0));
        chk("rst_max",   128'(if_u.result_max),   128'(0));
        chk("rst_mar",   128'(if_s.result_margin), 128'(0));
        chk("rst_err",   128'(if_u.err_len),      128'(1'b0));
        rst = 1'b1;
        @(negedge clk);

        q = {};
        foreach (spec_v[i]) q.push_back(sc(spec_v[i]));
        send_frame(q);
        chk("spec_idx",  128'(if_s.result_idx),        128'(1));
        chk("spec_max",  128'(if_s.result_max),        128'(9));
        chk("spec_sidx", 128'(if_s.result_second_idx), 128'(7));
        chk("spec_mar",  128'(if_s.result_margin),     128'(1));
        chk("spec_err",  128'(if_s.err_len),           128'(1'b0));
        check_frame(q, "spec", 0);

        q = {};
        repeat (NC) q.push_back(sc(5));
        send_frame(q);
        chk("eq_idx",  128'(if_s.result_idx),        128'(0));
        chk("eq_sidx", 128'(if_s.result_second_idx), 128'(1));
        chk("eq_mar",  128'(if_s.result_margin),     128'(0));
        check_frame(q, "eq", 0);

        big = '0;
        big[SW-1] = 1'b1;
        q = {};
        for (int i = 0; i < NC; i++) q.push_back((i == 4) ? big : sc(1));
        send_frame(q);
        chk("msb_u_idx", 128'(if_u.result_idx), 128'(4));
        chk("msb_s_idx", 128'(if_s.result_idx), 128'(0));
        check_frame(q, "msb", 1);

        rnd_frame(7, q);
        send_frame(q);
        chk("short_err", 128'(if_s.err_len), 128'(1'b1));
        check_frame(q, "short", 0);

        rnd_frame(12, q);
        send_frame(q);
        chk("long_err", 128'(if_u.err_len), 128'(1'b1));
        check_frame(q, "long", 0);

        rnd_frame(1, q);
        send_frame(q);
        check_frame(q, "one", 0);

        rnd_frame(NC, q);
        send_frame(q);
        check_frame(q, "stall", 5);

        // reset in the middle of a frame
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat(sc(1000 + i), 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 128'(if_s.result_valid), 128'(1'b0));
        chk("mrst_ready", 128'(if_u.score_ready),  128'(1'b0));
        chk("mrst_idx",   128'(if_s.result_idx),   128'(0));
        rst = 1'b1;
        @(negedge clk);
        rnd_frame(NC, q);
        send_frame(q);
        check_frame(q, "mrst", 0);

        // restart inside ACCUM
        pulse_start();
        for (int i = 0; i < 3; i++) send_beat({2'b01, {(SW-2){1'b1}}}, 1'b0);
        rnd_frame(NC, q);
        send_frame(q);
        check_frame(q, "abort", 0);

        for (int f = 0; f < 25; f++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 13)) : int'(NC);
            rnd_frame(n, q);
            send_frame(q);
            check_frame(q, $sformatf("rnd%0d", f), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
